// File: rtl/req_arbiter.sv
// Four-way request arbiter: registered one-hot grant + 3-bit code, hold timeout.
// Ports: clk, rst_n, req[4:1] in; gnt[4:1], gnt_code, busy, timeout out. Macro: ROUND_ROBIN_EN.
module req_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:1] req,
  output logic [4:1] gnt,
  output logic [2:0] gnt_code,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [2:0] code_q, code_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       to_q, to_d;

  logic [3:0] req_v;
  logic [3:0] last_oh;
  logic [3:0] req_m;
  logic [3:0] pick;
  logic       own_req;

  function automatic logic [2:0] enc(input logic [3:0] g);
    logic [2:0] c;
    c = 3'd0;
    if (g[3])      c = 3'd4;
    else if (g[2]) c = 3'd3;
    else if (g[1]) c = 3'd2;
    else if (g[0]) c = 3'd1;
    return c;
  endfunction

  function automatic logic [3:0] dec(input logic [2:0] c);
    logic [3:0] g;
    g = 4'b0000;
    case (c)
      3'd1:    g = 4'b0001;
      3'd2:    g = 4'b0010;
      3'd3:    g = 4'b0100;
      3'd4:    g = 4'b1000;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

`ifdef ROUND_ROBIN_EN
  // Search starts one below the last owner and wraps; the last
  // owner is visited last (k=4 lands back on it).
  function automatic logic [3:0] arb(
    input logic [3:0] r,
    input logic [2:0] last
  );
    logic [3:0] g;
    logic [1:0] base;
    logic [1:0] idx;
    g    = 4'b0000;
    base = 2'(last - 3'd1);
    for (int k = 1; k <= 4; k++) begin
      idx = base - 2'(k);
      if (g == 4'b0000 && r[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  assign pick = arb(req_m, last_q);
`else
  function automatic logic [3:0] arb(input logic [3:0] r);
    logic [3:0] g;
    g = 4'b0000;
    if (r[3])      g = 4'b1000;
    else if (r[2]) g = 4'b0100;
    else if (r[1]) g = 4'b0010;
    else if (r[0]) g = 4'b0001;
    return g;
  endfunction

  assign pick = arb(req_m);
`endif

  assign req_v   = req;
  assign last_oh = dec(last_q);
  assign own_req = |(req_v & gnt_q);

  // After a hold expiry the old owner sits out one arbitration,
  // unless nobody else is asking.
  always_comb begin
    req_m = req_v;
    if (to_q && |(req_v & ~last_oh)) req_m = req_v & ~last_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      code_q  <= 3'd0;
      last_q  <= 3'd4;
      hold_q  <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      code_q  <= code_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    code_d  = code_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE, RELEASE: begin
        if (|req_m) begin
          state_d = BUSY;
          gnt_d   = pick;
          code_d  = enc(pick);
          last_d  = enc(pick);
          hold_d  = 8'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          code_d  = 3'd0;
          hold_d  = 8'd0;
        end
      end
      BUSY: begin
        // A drop wins over an expiry on the same edge.
        if (!own_req) begin
          state_d = RELEASE;
          gnt_d   = 4'b0000;
          code_d  = 3'd0;
          hold_d  = 8'd0;
        end else if (hold_q == 8'(MAX_HOLD)) begin
          state_d = RELEASE;
          gnt_d   = 4'b0000;
          code_d  = 3'd0;
          hold_d  = 8'd0;
          to_d    = 1'b1;
        end else begin
          hold_d  = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        code_d  = 3'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    gnt      = gnt_q;
    gnt_code = code_q;
    busy     = |gnt_q;
    timeout  = to_q;
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter (MAX_HOLD=8).
// Fixed-priority vectors by default; rotation vectors with ROUND_ROBIN_EN.
module tb_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:1] req;
  logic [4:1] gnt;
  logic [2:0] gnt_code;
  logic       busy;
  logic       timeout;

  int checks;
  int errors;

  req_arbiter #(.MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_code (gnt_code),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [3:0] g, input logic [2:0] c);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_code"}, 32'(gnt_code), 32'(c));
    chk({tag, "_busy"}, 32'(busy), 32'(|g));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    #3;
    chk_g("rst", 4'b0000, 3'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    step();
    chk_g("rst_clk", 4'b0000, 3'd0);
    req   = 4'b0000;
    rst_n = 1'b1;
  endtask

`ifdef ROUND_ROBIN_EN
  task automatic run_tests();
    logic [3:0] ord [5];
    logic [2:0] cod [5];
    ord = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    cod = '{3'd3, 3'd2, 3'd1, 3'd4, 3'd3};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_g($sformatf("rr%0d_a", i), ord[i], cod[i]);
      step();
      chk_g($sformatf("rr%0d_b", i), ord[i], cod[i]);
      req = 4'b1111 & ~ord[i];
      step();
      chk_g($sformatf("rr%0d_rel", i), 4'b0000, 3'd0);
      req = 4'b1111;
    end
  endtask
`else
  task automatic run_tests();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk_g($sformatf("idle%0d", i), 4'b0000, 3'd0);
    end

    req = 4'b0011;
    step();
    chk_g("pri_0011", 4'b0010, 3'd2);
    req = 4'b0000;
    step();
    chk_g("pri_rel", 4'b0000, 3'd0);
    chk("pri_rel_to", 32'(timeout), 32'd0);
    step();

    req = 4'b1001;
    step();
    chk_g("pri_1001", 4'b1000, 3'd4);
    req = 4'b0000;
    step();
    step();

    req = 4'b0001;
    step();
    chk_g("own1", 4'b0001, 3'd1);
    req = 4'b1001;
    step();
    chk_g("nopre_a", 4'b0001, 3'd1);
    step();
    chk_g("nopre_b", 4'b0001, 3'd1);
    req = 4'b1000;
    step();
    chk_g("turn", 4'b0000, 3'd0);
    chk("turn_to", 32'(timeout), 32'd0);
    step();
    chk_g("after_turn", 4'b1000, 3'd4);
    req = 4'b0000;
    step();
    step();

    req = 4'b1100;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_g($sformatf("hold%0d", i), 4'b1000, 3'd4);
    end
    step();
    chk_g("to_rel", 4'b0000, 3'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    step();
    chk_g("to_mask", 4'b0100, 3'd3);
    chk("to_clr", 32'(timeout), 32'd0);
    req = 4'b0000;
    step();
    step();

    req = 4'b1000;
    for (int i = 1; i <= 8; i++) step();
    chk_g("sole_hold8", 4'b1000, 3'd4);
    req = 4'b0000;
    step();
    chk_g("drop_exp", 4'b0000, 3'd0);
    chk("drop_exp_to", 32'(timeout), 32'd0);
    step();

    req = 4'b1000;
    for (int i = 1; i <= 8; i++) step();
    step();
    chk("sole_to", 32'(timeout), 32'd1);
    step();
    chk_g("sole_regnt", 4'b1000, 3'd4);

    #2;
    rst_n = 1'b0;
    #1;
    chk_g("midrst", 4'b0000, 3'd0);
    req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    chk_g("post_rst", 4'b0000, 3'd0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    run_tests();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Sequential arbiter that shares a single downstream resource among four requesters using the team's MSB-first priority-encoding rule (highest set request bit wins, lower bits ignored). It registers the winner as a one-hot grant plus a 3-bit binary code in the same format as the 4-to-3 priority encoder. It holds the grant while the owner keeps requesting, bounded by a hold timeout. It sits between the request lines and the shared resource's enable/select inputs.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal range 2..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  [4:1]  request per requester; level, held until served.
- gnt  output  [4:1]  one-hot grant, registered; all-zero when none.
- gnt_code  output  [2:0]  binary index of the owner (3'b001..3'b100); 3'b000 when no grant.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse in the RELEASE cycle entered because of hold expiry.

## Operation
- States: IDLE, BUSY, RELEASE.
- Reset (async, rst_n=0): state IDLE, gnt=0, gnt_code=0, busy=0, timeout=0, hold_cnt=0, last_owner=4.
- IDLE
  - req==0: stay.
  - Any req bit set: arbitrate, load winner into gnt/gnt_code, go BUSY, hold_cnt=1.
- BUSY
  - Owner's req high and hold_cnt<MAX_HOLD: stay; hold_cnt++.
  - Owner's req low: go RELEASE, timeout=0.
  - hold_cnt==MAX_HOLD with req still high: go RELEASE, timeout=1.
  - Requests from other requesters never pre-empt the owner.
- RELEASE
  - gnt=0, busy=0 for exactly one cycle (turnaround).
  - At the end of the cycle: arbitrate the current req and go BUSY, or go IDLE if req==0.
  - After a timeout, the previous owner is masked from this one arbitration only if another req bit is set; if it is the sole requester it is re-granted.
- Arbitration (default, fixed priority): req[4] > req[3] > req[2] > req[1].
- last_owner is updated on every grant.
- gnt_code always equals the binary index of the set gnt bit.
- busy is identical to |gnt.

## Timing
- Request-to-grant latency is one cycle. A req sampled at edge k in IDLE gives gnt valid after edge k.
- Owner drop: if req drops before edge k, gnt is low after edge k (RELEASE). The next grant is valid after edge k+1.
- Maximum continuous grant is MAX_HOLD cycles. It is followed by exactly one RELEASE cycle.
- Simultaneous owner drop and hold expiry at the same edge is treated as a drop, so timeout=0.
- Reset mid-grant clears gnt immediately (asynchronously). No RELEASE cycle is produced.
- Requests that appear and vanish between edges are not seen. Only values sampled at the rising edge count.

## Configuration
- ROUND_ROBIN_EN defined:
  - Priority rotates. The search order starts at last_owner-1 and continues downward with wrap-around (e.g. last_owner=3 gives order 2,1,4,3).
  - last_owner has the lowest priority.
  - After reset, last_owner=4, so the first search order is 3,2,1,4.
- ROUND_ROBIN_EN undefined: fixed MSB-first priority as described under Operation.
- Timeout masking applies in both modes.

## Test plan
- Reset and idle (fixed priority, MAX_HOLD=8):
  - Assert rst_n=0 with req=4'b1111 → all outputs 0.
  - Release reset with req=0 for 5 cycles → gnt stays 0.
- Priority pick:
  - req=4'b0011 → gnt=4'b0010, gnt_code=3'b010 one cycle later.
  - req=4'b1001 from IDLE → gnt=4'b1000, gnt_code=3'b100.
- No pre-emption and turnaround:
  - Owner 1 granted, then req changes to 4'b1001 → gnt stays 4'b0001.
  - req[1] drops → one cycle gnt=0, then gnt=4'b1000.
- Timeout:
  - req=4'b1100 held → gnt=4'b1000 for exactly 8 cycles.
  - Then RELEASE with timeout=1 for one cycle → gnt=4'b0100.
  - With req=4'b1000 only, owner 4 is re-granted after the RELEASE cycle.
- Mid-grant reset: rst_n=0 during BUSY → gnt=0 immediately, without waiting for the clock edge.
- Round robin (ROUND_ROBIN_EN defined), req=4'b1111 held, each owner dropping after 2 cycles → grant order 3,2,1,4,3.
